// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: md_op codes, FSM states
// and small decode helpers reused by the instruction decoder.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Codes 0..3 are the timed arithmetic operations.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] sext_a;
    logic signed [63:0] sext_b;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        divu_b;
    logic [31:0]        q_u;
    logic [31:0]        r_u;

    assign sext_a = {{32{a[31]}}, a};
    assign sext_b = {{32{b[31]}}, b};
    assign prod_s = sext_a * sext_b;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by one; the controller never commits that result.
    assign mag_a  = a[31] ? (32'd0 - a) : a;
    assign mag_b  = (b == 32'd0) ? 32'd1 : (b[31] ? (32'd0 - b) : b);
    assign q_mag  = mag_a / mag_b;
    assign r_mag  = mag_a % mag_b;
    assign divu_b = (b == 32'd0) ? 32'd1 : b;
    assign q_u    = a / divu_b;
    assign r_u    = a % divu_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = a[31] ? (32'd0 - r_mag) : r_mag;
            end
            MD_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, times arithmetic ops over a fixed
// cycle count and raises a stall for D-stage instructions that need the unit.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        mt_we,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_t   state_reg, state_next;
    logic [3:0]  cnt_reg,   cnt_next;
    logic [2:0]  op_reg,    op_next;
    logic [31:0] a_reg,     a_next;
    logic [31:0] b_reg,     b_next;
    logic [31:0] hi_reg,    hi_next;
    logic [31:0] lo_reg,    lo_next;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    md_arith u_arith (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                // start has priority over mt_we; non-arith codes with start do nothing.
                if (start) begin
                    if (md_is_arith(md_op)) begin
                        op_next    = md_op;
                        a_next     = rs_val;
                        b_next     = rt_val;
                        cnt_next   = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
                        state_next = ST_RUN;
                    end
                end else if (mt_we) begin
                    if (md_op == MD_MTHI) begin
                        hi_next = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_next = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                    // Divide by zero burns the full period but leaves HI/LO alone.
                    if (!(md_is_div(op_reg) && (b_reg == 32'd0))) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state_reg == ST_RUN);
    assign stall_md = md_use_D & (busy | start);
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus pushes expected commits, a monitor
// checks HI/LO and busy length whenever busy falls.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        mt_we;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .mt_we    (mt_we),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy-high cycles, compare on the falling edge of busy.
    initial begin : monitor
        logic prev_busy;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bcnt++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, hi, e.exp_hi);
                    chk({e.name, "_lo"}, lo, e.exp_lo);
                    chk({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cycles));
                    $display("txn %s: hi=%h lo=%h busy_cycles=%0d", e.name, hi, lo, bcnt);
                end
                bcnt = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name   = name;
        e.exp_hi = h;
        e.exp_lo = l;
        e.cycles = c;
        sb_q.push_back(e);
    endtask

    // Operands are scrambled after the start edge to prove they were latched.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin : stim
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        mt_we    = 1'b0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        md_use_D = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", 32'(stall_md), 32'd0);
        md_use_D = 1'b0;

        // MULT -2 * 3; HI/LO must hold during busy
        push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        start_op(MD_MULT, 32'hFFFFFFFE, 32'd3);
        @(negedge clk);
        chk("mult_hold_hi", hi, 32'd0);
        chk("mult_hold_lo", lo, 32'd0);
        wait_idle("mult");

        push("multu", 32'hFFFFFFFE, 32'h00000001, 5);
        start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("multu");

        push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        start_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle("div");

        push("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        start_op(MD_DIVU, 32'd7, 32'd0);
        wait_idle("divu_by0");

        // MTHI then MTLO back to back
        mt_we  = 1'b1;
        md_op  = MD_MTHI;
        rs_val = 32'h12345678;
        tick();
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'hFFFFFFFD);
        chk("mthi_busy", 32'(busy), 32'd0);
        md_op  = MD_MTLO;
        rs_val = 32'h9ABCDEF0;
        tick();
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        $display("txn mthi/mtlo: hi=%h lo=%h", hi, lo);

        // Reserved op with mt_we, and MTHI code with start: no effect
        md_op  = 3'd6;
        rs_val = 32'hCAFEF00D;
        tick();
        mt_we  = 1'b0;
        start  = 1'b1;
        md_op  = MD_MTHI;
        tick();
        start  = 1'b0;
        chk("noop_hi", hi, 32'h12345678);
        chk("noop_lo", lo, 32'h9ABCDEF0);
        chk("noop_busy", 32'(busy), 32'd0);

        push("div_ovf", 32'h00000000, 32'h80000000, 10);
        start_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf");

        // Stall window, plus start and mt_we pulsed mid-run
        push("mult_stall", 32'h00000001, 32'h00000000, 5);
        md_use_D = 1'b1;
        start    = 1'b1;
        md_op    = MD_MULT;
        rs_val   = 32'h00010000;
        rt_val   = 32'h00010000;
        #1;
        chk("stall_start_cycle", 32'(stall_md), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_busy%0d", i), 32'(stall_md), 32'd1);
            if (i == 1) begin
                start  = 1'b1;
                md_op  = MD_MULTU;
                rs_val = 32'd5;
                rt_val = 32'd7;
            end else if (i == 2) begin
                start  = 1'b0;
                mt_we  = 1'b1;
                md_op  = MD_MTHI;
                rs_val = 32'hDEADBEEF;
            end else if (i == 3) begin
                mt_we  = 1'b0;
            end
        end
        @(negedge clk);
        chk("stall_after_commit", 32'(stall_md), 32'd0);
        md_use_D = 1'b0;
        tick();

        // Reset during DIV busy cycle 4: no commit, HI/LO cleared
        push("div_reset", 32'h00000000, 32'h00000000, 4);
        start_op(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (15) tick();
        chk("late_hi", hi, 32'd0);
        chk("late_lo", lo, 32'd0);
        chk("late_busy", 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
